// File: rtl/led_pwm_if.sv
// Bus bundle for the LED PWM dimmer: run enable, duty load path and PWM/status outputs.
interface led_pwm_if #(
    parameter int CHANNELS = 8,
    parameter int RES      = 8
);
    logic                     en;
    logic                     load;
    logic [CHANNELS*RES-1:0]  duty;
    logic [CHANNELS-1:0]      pwm;
    logic                     period_tick;
    logic                     pending;

    modport master (
        output en, load, duty,
        input  pwm, period_tick, pending
    );

    modport slave (
        input  en, load, duty,
        output pwm, period_tick, pending
    );
endinterface

// File: rtl/led_pwm.sv
// Multi-channel LED PWM dimmer with double-buffered duty values that switch only at
// period boundaries (or while disabled), so no pulse is ever truncated.
module led_pwm #(
    parameter int CHANNELS = 8,
    parameter int RES      = 8,
    parameter int PRESCALE = 1
) (
    input logic      clk,
    input logic      rstn,
    led_pwm_if.slave bus
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST   = PW'(PRESCALE - 1);
    // phase never reaches all-ones, which is what makes the maximum duty "always on"
    localparam logic [RES-1:0] PHASE_LAST = {{(RES-1){1'b1}}, 1'b0};

    logic [PW-1:0]                   pre_q, pre_d;
    logic [RES-1:0]                  phase_q, phase_d;
    logic [CHANNELS-1:0][RES-1:0]    shadow_q, shadow_d;
    logic [CHANNELS-1:0][RES-1:0]    active_q, active_d;
    logic [CHANNELS-1:0]             pwm_q, pwm_d;
    logic                            tick_q, tick_d;
    logic                            pending_q, pending_d;
    logic                            step, wrap, xfer;

    always_comb begin
        step      = bus.en && (pre_q == PRE_LAST);
        wrap      = step && (phase_q == PHASE_LAST);
        xfer      = wrap || !bus.en;

        pre_d     = '0;
        phase_d   = '0;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        pwm_d     = '0;
        tick_d    = wrap;

        if (bus.en) begin
            pre_d = step ? '0 : pre_q + PW'(1);
            if (wrap)
                phase_d = '0;
            else if (step)
                phase_d = phase_q + RES'(1);
            else
                phase_d = phase_q;
        end

        if (bus.load) begin
            shadow_d  = bus.duty;
            pending_d = 1'b1;
        end

        // a load coinciding with a transfer bypasses the shadow and never shows as pending
        if (xfer) begin
            active_d  = bus.load ? bus.duty : shadow_q;
            pending_d = 1'b0;
        end

        for (int unsigned i = 0; i < CHANNELS; i++)
            pwm_d[i] = bus.en && (phase_q < active_q[i]);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q     <= '0;
            phase_q   <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pwm_q     <= '0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pwm_q     <= pwm_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign bus.pwm         = pwm_q;
    assign bus.period_tick = tick_q;
    assign bus.pending     = pending_q;
endmodule

// File: tb/tb_led_pwm.sv
// Directed bench for led_pwm: cycle table at RES=4/PRESCALE=1, plus reset and prescaler sequences.
module tb_led_pwm;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    led_pwm_if #(.CHANNELS(2), .RES(4)) bus  ();
    led_pwm_if #(.CHANNELS(2), .RES(4)) bus3 ();

    led_pwm #(.CHANNELS(2), .RES(4), .PRESCALE(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    led_pwm #(.CHANNELS(2), .RES(4), .PRESCALE(3)) dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3)
    );

    typedef struct {
        int unsigned n;
        logic        en;
        logic        load;
        logic [3:0]  d0;
        logic [3:0]  d1;
        logic [1:0]  pwm;
        logic        tick;
        logic        pend;
    } vec_t;

    vec_t tbl[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    function automatic void add(input int unsigned n, input logic en, input logic load,
                                input logic [3:0] d0, input logic [3:0] d1,
                                input logic [1:0] pwm, input logic tick, input logic pend);
        vec_t v;
        v.n = n; v.en = en; v.load = load; v.d0 = d0; v.d1 = d1;
        v.pwm = pwm; v.tick = tick; v.pend = pend;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] outs(input logic [1:0] p, input logic t, input logic q);
        return {28'd0, p, t, q};
    endfunction

    initial begin
        int unsigned highs0, highs1, ticks, waited;
        logic        got;

        rstn      = 1'b0;
        bus.en    = 1'b0; bus.load  = 1'b0; bus.duty  = '0;
        bus3.en   = 1'b0; bus3.load = 1'b0; bus3.duty = '0;

        #3;
        check("reset_state", outs(bus.pwm, bus.period_tick, bus.pending), 32'd0);
        check("reset_state_p3", outs(bus3.pwm, bus3.period_tick, bus3.pending), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;

        // n, en, load, d0, d1, pwm, tick, pending
        add(2,  0, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 1, 5,  0,  2'b00, 0, 1);   // basic duty 5/0
        add(13, 1, 0, 0,  0,  2'b00, 0, 1);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(5,  1, 0, 0,  0,  2'b01, 0, 0);
        add(9,  1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(5,  1, 0, 0,  0,  2'b01, 0, 0);
        add(9,  1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(5,  1, 0, 0,  0,  2'b01, 0, 0);   // mid-period load at phase 7
        add(2,  1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 1, 10, 0,  2'b00, 0, 1);
        add(6,  1, 0, 0,  0,  2'b00, 0, 1);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(10, 1, 0, 0,  0,  2'b01, 0, 0);
        add(4,  1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 1, 3,  0,  2'b00, 1, 0);   // load in the wrap cycle
        add(3,  1, 0, 0,  0,  2'b01, 0, 0);
        add(11, 1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(1,  1, 1, 15, 14, 2'b01, 0, 1);   // full scale
        add(2,  1, 0, 0,  0,  2'b01, 0, 1);
        add(11, 1, 0, 0,  0,  2'b00, 0, 1);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(14, 1, 0, 0,  0,  2'b11, 0, 0);
        add(1,  1, 0, 0,  0,  2'b01, 1, 0);
        add(14, 1, 0, 0,  0,  2'b11, 0, 0);
        add(1,  1, 0, 0,  0,  2'b01, 1, 0);
        add(1,  1, 1, 5,  0,  2'b11, 0, 1);   // enable drop at phase 3
        add(2,  1, 0, 0,  0,  2'b11, 0, 1);
        add(1,  0, 0, 0,  0,  2'b00, 0, 0);
        add(3,  0, 0, 0,  0,  2'b00, 0, 0);
        add(5,  1, 0, 0,  0,  2'b01, 0, 0);
        add(9,  1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(1,  0, 1, 2,  0,  2'b00, 0, 0);   // load while disabled
        add(2,  1, 0, 0,  0,  2'b01, 0, 0);
        add(12, 1, 0, 0,  0,  2'b00, 0, 0);
        add(1,  1, 0, 0,  0,  2'b00, 1, 0);
        add(1,  1, 1, 7,  0,  2'b01, 0, 1);

        foreach (tbl[r]) begin
            for (int unsigned k = 0; k < tbl[r].n; k++) begin
                bus.en   = tbl[r].en;
                bus.load = tbl[r].load;
                bus.duty = {tbl[r].d1, tbl[r].d0};
                @(posedge clk); #1;
                check($sformatf("row%0d_cyc%0d", r, k),
                      outs(bus.pwm, bus.period_tick, bus.pending),
                      outs(tbl[r].pwm, tbl[r].tick, tbl[r].pend));
            end
        end
        bus.load = 1'b0;

        // asynchronous reset mid-period with pwm and pending high
        #3 rstn = 1'b0;
        #1 check("async_reset", outs(bus.pwm, bus.period_tick, bus.pending), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("reset_hold", outs(bus.pwm, bus.period_tick, bus.pending), 32'd0);
        rstn = 1'b1;

        highs0 = 0; ticks = 0;
        for (int unsigned k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.pwm != 2'b00) highs0++;
            if (bus.period_tick) ticks++;
        end
        check("dark_after_reset", highs0, 0);
        check("ticks_after_reset", ticks, 2);

        bus.load = 1'b1; bus.duty = {4'd9, 4'd0};
        @(posedge clk); #1;
        bus.load = 1'b0;
        check("pending_after_load", bus.pending, 1);
        for (int unsigned k = 0; k < 14; k++) begin
            @(posedge clk); #1;
        end
        check("wrap_after_load", outs(bus.pwm, bus.period_tick, bus.pending), outs(2'b00, 1'b1, 1'b0));
        highs0 = 0; highs1 = 0;
        for (int unsigned k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (bus.pwm[0]) highs0++;
            if (bus.pwm[1]) highs1++;
        end
        check("ch1_duty9", highs1, 9);
        check("ch0_duty0", highs0, 0);
        check("tick_before_reset", bus.period_tick, 1);
        #2 rstn = 1'b0;
        #1 check("async_reset_tick", outs(bus.pwm, bus.period_tick, bus.pending), 32'd0);
        @(posedge clk); #1;
        rstn   = 1'b1;
        bus.en = 1'b0;

        // prescaler 3: 45-cycle period, 15 high cycles for duty 5
        bus3.load = 1'b1; bus3.duty = {4'd0, 4'd5};
        @(posedge clk); #1;
        bus3.load = 1'b0;
        check("p3_load_disabled_no_pending", bus3.pending, 0);
        bus3.en = 1'b1;
        got = 1'b0; waited = 0;
        while (!got && waited < 200) begin
            @(posedge clk); #1;
            waited++;
            if (bus3.period_tick) got = 1'b1;
        end
        check("p3_first_tick_timeout", got, 1);
        check("p3_first_period", waited, 45);
        highs0 = 0; ticks = 0;
        for (int unsigned k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (bus3.pwm[0]) highs0++;
            if (bus3.period_tick) ticks++;
        end
        check("p3_high_cycles", highs0, 15);
        check("p3_tick_count", ticks, 1);
        check("p3_tick_at_end", bus3.period_tick, 1);
        check("p3_ch1_dark", bus3.pwm[1], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/led_pwm.md
# led_pwm

Multi-channel PWM dimmer for the board LEDs, placed directly downstream of the LED counters (`m1`/`cnt`). It takes a packed duty word per LED and drives each LED pin with a pulse-width-modulated signal, so counter values show as brightness instead of on/off. New duty values are double-buffered and take effect only at a PWM period boundary, so a duty change never produces a truncated or glitched pulse.

## Interface
- `CHANNELS`, default 8: number of LED outputs.
- `RES`, default 8: duty resolution in bits. The period is 2^RES−1 steps.
- `PRESCALE`, default 1: `clk` cycles per PWM step. Must be ≥ 1.

- `clk`  in  1: clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `en`  in  1: run enable. Low forces the outputs off and holds the counters at 0.
- `duty`  in  CHANNELS*RES: packed duty values. Channel i occupies `[i*RES +: RES]`.
- `load`  in  1: single-cycle strobe that captures `duty` into the shadow register.
- `pwm`  out  CHANNELS: registered PWM outputs, active-high.
- `period_tick`  out  1: one-cycle pulse after each period wrap.
- `pending`  out  1: the shadow register holds duty values not yet applied.

## Operation
Internal state:
- `pre`: prescaler, ⌈log2 PRESCALE⌉ bits, minimum 1 bit.
- `phase`: RES bits, range 0..2^RES−2.
- `shadow[i]`, `active[i]`: RES bits each.

Reset (asynchronous):
- `pre`, `phase`, `shadow`, `active` are all cleared to 0.
- `pwm`, `period_tick`, `pending` are all cleared to 0.

Per clock edge:
- **step** = `en && pre == PRESCALE−1`.
  - When `en` = 1: `pre` increments and returns to 0 on step.
  - When `en` = 0: `pre` and `phase` are forced to 0.
- **wrap** = `step && phase == 2^RES−2`.
  - On wrap: `phase` ← 0.
  - On a step that is not a wrap: `phase` ← `phase` + 1.
- **load**: `shadow` ← `duty` and `pending` ← 1.
- **Transfer** happens on wrap, or on any cycle with `en` = 0:
  - `active` ← (`load` ? `duty` : `shadow`).
  - `pending` ← 0.
  - If `load` coincides with a transfer, the new `duty` is applied directly and `pending` ends at 0.
- **Outputs**:
  - `pwm[i]` ← `en && (phase < active[i])`, an unsigned RES-bit compare.
  - `period_tick` ← wrap.

Duty mapping:
- Duty 0 means always off.
- Duty 2^RES−1 means always on, because `phase` never reaches 2^RES−1.
- Duty d gives exactly d high steps per period.

`duty` is sampled only when `load` = 1. It is a don't-care at all other times.

## Timing
- Outputs are registered. `pwm` reflects `phase` and `active` from the previous cycle, giving a one-cycle latency.
- Period length is (2^RES−1)·PRESCALE `clk` cycles.
- After `en` rises:
  - The first period starts with `phase` = 0 in the first `en`-high cycle.
  - `pwm` first goes high on the following edge when d > 0.
- When `en` falls, `pwm` goes to 0 one edge later. The next enable starts a fresh period at `phase` 0 with the latest shadow values.
- A `load` in the middle of a period:
  - `pending` = 1 starting the next cycle.
  - The old duty continues to the end of the period.
  - The new duty applies from the `pwm` value computed at `phase` 0 of the next period.
- `period_tick` is high during the cycle in which `phase` first reads 0 after a wrap, and never while `en` = 0.
- `rstn` asserted in the middle of a period clears all outputs immediately, without waiting for a clock edge. After release, `active` = 0 (all LEDs dark) until the next `load`.

## Test plan
Unless stated otherwise: `CHANNELS`=2, `RES`=4 (period 15 steps), `PRESCALE`=1.

- **Basic duty.** Reset, then `load` ch0=5, ch1=0 with `en`=1. Required: ch0 is high for exactly 5 consecutive cycles in every 15-cycle window, ch1 stays 0, and `period_tick` pulses every 15 cycles.
- **Full scale.** `load` ch0=15, ch1=14. Required: ch0 is constantly 1 once running; ch1 is low for exactly 1 cycle in every 15.
- **Mid-period load.** With ch0=5 running, `load` ch0=10 at `phase` 7. Required: `pending`=1 until the wrap; the current period keeps 5 high cycles; the next period has 10 high cycles and `pending` returns to 0 alongside `period_tick`.
- **Load at wrap.** Assert `load` ch0=3 in the wrap cycle. Required: the very next period has 3 high cycles and `pending` never rises.
- **Prescaler.** `PRESCALE`=3, ch0=5. Required: 45-cycle period with 15 high cycles; `period_tick` width stays 1 cycle.
- **En and reset.** Deassert `en` mid-period, then reassert it. Required: `pwm`=0 one cycle after the fall; `phase` restarts at 0. Then pulse `rstn` low: `pwm`, `period_tick`, `pending` go to 0 asynchronously, and after release `pwm` stays 0 until a new `load`.
